// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB requester.
package apb_pkg;

    localparam int unsigned APB_ADDR_W      = 32;
    localparam int unsigned APB_DATA_W      = 32;
    localparam int unsigned APB_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive ACCESS wait cycles; expired fires on the TIMEOUT_CYC-th one.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;

    // Current wait cycle is the last allowed one.
    assign expired = count_en && (count_q == LAST);

    // Wait-cycle counter; cleared outside wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-command APB requester: IDLE -> SETUP -> ACCESS, one-cycle response pulse.
// Optional ACCESS wait-state timeout compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
    input  logic              P_clk,
    input  logic              P_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] P_addr,
    output logic              P_selx,
    output logic              P_enable,
    output logic              P_write,
    output logic [DATA_W-1:0] P_wdata,
    input  logic              P_ready,
    input  logic              P_slverr,
    input  logic [DATA_W-1:0] P_rdata
);

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              accept, complete, abort, expired;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk      (P_clk),
        .rst_n    (P_rst_n),
        .clear    ((state_q != ACCESS) || P_ready),
        .count_en ((state_q == ACCESS) && !P_ready),
        .expired  (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge P_clk or negedge P_rst_n) begin
        if (!P_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; P_ready wins over a simultaneous timeout.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (P_ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (expired) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command capture and response registers.
    always_ff @(posedge P_clk or negedge P_rst_n) begin
        if (!P_rst_n) begin
            addr_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                write_q <= cmd_write;
                wdata_q <= cmd_write ? cmd_wdata : '0;
            end
            rsp_valid_q <= complete || abort;
            if (complete) begin
                rsp_err_q     <= P_slverr;
                rsp_timeout_q <= 1'b0;
                rsp_rdata_q   <= write_q ? '0 : P_rdata;
            end else if (abort) begin
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
                rsp_rdata_q   <= '0;
            end
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign P_selx      = (state_q != IDLE);
    assign P_enable    = (state_q == ACCESS);
    assign P_addr      = addr_q;
    assign P_write     = write_q;
    assign P_wdata     = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed table-driven bench for apb_master, plus reset and timeout sequences.
module tb_apb_master;

    localparam int unsigned TO = 4;

    logic        P_clk = 1'b0;
    logic        P_rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] P_addr, P_wdata, P_rdata;
    logic        P_selx, P_enable, P_write, P_ready, P_slverr;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic        cmd_ready, selx, enable, write;
        logic [31:0] addr, wdata;
        logic        rsp_valid, rsp_err, rsp_timeout;
        logic [31:0] rsp_rdata;
    } out_t;

    typedef struct packed {
        logic        cv, cw;
        logic [31:0] a, d;
        logic        rdy, serr;
        logic [31:0] rd;
        out_t        exp;
    } vec_t;

    apb_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .P_clk       (P_clk),
        .P_rst_n     (P_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .rsp_rdata   (rsp_rdata),
        .P_addr      (P_addr),
        .P_selx      (P_selx),
        .P_enable    (P_enable),
        .P_write     (P_write),
        .P_wdata     (P_wdata),
        .P_ready     (P_ready),
        .P_slverr    (P_slverr),
        .P_rdata     (P_rdata)
    );

    always #5 P_clk = ~P_clk;

    function automatic vec_t v(bit cv, bit cw, int a, int d, bit rdy, bit serr, int rd,
                               bit crdy, bit sel, bit en, bit w, int ea, int ed,
                               bit rv, bit err, int erd);
        vec_t r;
        r.cv = cv; r.cw = cw; r.a = a; r.d = d;
        r.rdy = rdy; r.serr = serr; r.rd = rd;
        r.exp = '{cmd_ready: crdy, selx: sel, enable: en, write: w, addr: ea, wdata: ed,
                  rsp_valid: rv, rsp_err: err, rsp_timeout: 1'b0, rsp_rdata: erd};
        return r;
    endfunction

    function automatic out_t sample();
        return '{cmd_ready: cmd_ready, selx: P_selx, enable: P_enable, write: P_write,
                 addr: P_addr, wdata: P_wdata, rsp_valid: rsp_valid, rsp_err: rsp_err,
                 rsp_timeout: rsp_timeout, rsp_rdata: rsp_rdata};
    endfunction

    // Fields that are undefined outside a transfer / response are zeroed on both sides.
    function automatic out_t mask(out_t o, bit keep_apb, bit keep_rsp);
        out_t r = o;
        if (!keep_apb) begin r.write = 1'b0; r.addr = '0; r.wdata = '0; end
        if (!keep_rsp) begin r.rsp_err = 1'b0; r.rsp_timeout = 1'b0; r.rsp_rdata = '0; end
        return r;
    endfunction

    task automatic check(string name, out_t act, out_t exp, bit full);
        out_t a = full ? act : mask(act, exp.selx, exp.rsp_valid);
        out_t e = full ? exp : mask(exp, exp.selx, exp.rsp_valid);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, a, e);
    endtask

    task automatic drive(bit cv, bit cw, int a, int d, bit rdy, bit serr, int rd);
        cmd_valid = cv; cmd_write = cw; cmd_addr = a; cmd_wdata = d;
        P_ready = rdy; P_slverr = serr; P_rdata = rd;
    endtask

    task automatic step();
        @(posedge P_clk);
        #1;
    endtask

    vec_t vecs[21];
    out_t idle_o;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        vecs[0]  = v(1,1,1,7,         1,0,0,       1,0,0,0,0,0,           0,0,0);
        vecs[1]  = v(0,0,0,0,         1,0,0,       0,1,0,1,1,7,           0,0,0);
        vecs[2]  = v(0,0,0,0,         1,0,0,       0,1,1,1,1,7,           0,0,0);
        vecs[3]  = v(1,0,2,'hFF,      0,0,0,       1,0,0,0,0,0,           1,0,0);
        vecs[4]  = v(0,0,0,0,         0,1,'h11,    0,1,0,0,2,0,           0,0,0);
        vecs[5]  = v(1,1,9,9,         0,1,'h11,    0,1,1,0,2,0,           0,0,0);
        vecs[6]  = v(1,1,9,9,         0,0,0,       0,1,1,0,2,0,           0,0,0);
        vecs[7]  = v(0,0,0,0,         0,1,'h22,    0,1,1,0,2,0,           0,0,0);
        vecs[8]  = v(0,0,0,0,         1,0,'h5A,    0,1,1,0,2,0,           0,0,0);
        vecs[9]  = v(0,0,0,0,         0,0,0,       1,0,0,0,0,0,           1,0,'h5A);
        vecs[10] = v(1,0,3,0,         0,0,0,       1,0,0,0,0,0,           0,0,0);
        vecs[11] = v(0,0,0,0,         1,1,'hEE,    0,1,0,0,3,0,           0,0,0);
        vecs[12] = v(0,0,0,0,         1,1,'hC3,    0,1,1,0,3,0,           0,0,0);
        vecs[13] = v(1,1,'h10,'hAA,   0,0,0,       1,0,0,0,0,0,           1,1,'hC3);
        vecs[14] = v(1,1,'h20,'hBB,   0,0,0,       0,1,0,1,'h10,'hAA,     0,0,0);
        vecs[15] = v(1,1,'h20,'hBB,   1,1,'h77,    0,1,1,1,'h10,'hAA,     0,0,0);
        vecs[16] = v(1,1,'h20,'hBB,   0,0,0,       1,0,0,0,0,0,           1,1,0);
        vecs[17] = v(0,0,0,0,         0,0,0,       0,1,0,1,'h20,'hBB,     0,0,0);
        vecs[18] = v(0,0,0,0,         1,0,'h99,    0,1,1,1,'h20,'hBB,     0,0,0);
        vecs[19] = v(0,0,0,0,         0,0,0,       1,0,0,0,0,0,           1,0,0);
        vecs[20] = v(0,0,0,0,         0,0,0,       1,0,0,0,0,0,           0,0,0);

        idle_o = '{cmd_ready: 1'b1, default: '0};

        // Reset state, with a command already offered.
        P_rst_n = 1'b0;
        drive(1, 1, 'h3C, 'h3C, 1, 1, 'hFF);
        #1;
        check("reset_state", sample(), idle_o, 1'b1);
        step();
        step();
        check("reset_hold", sample(), idle_o, 1'b1);
        P_rst_n = 1'b1;

        // Table: first row is the first cycle after reset release.
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].cv, vecs[i].cw, vecs[i].a, vecs[i].d,
                  vecs[i].rdy, vecs[i].serr, vecs[i].rd);
            check($sformatf("vec%0d", i), sample(), vecs[i].exp, 1'b0);
            step();
        end

        // Reset during ACCESS aborts without a response.
        drive(1, 0, 'h44, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        check("rst_pre_access", sample(),
              '{cmd_ready: 1'b0, selx: 1'b1, enable: 1'b1, write: 1'b0, addr: 'h44,
                default: '0}, 1'b0);
        #2;
        P_rst_n = 1'b0;
        #1;
        check("rst_mid_access", sample(), idle_o, 1'b1);
        P_ready = 1'b1;
        P_rdata = 'h12;
        step();
        check("rst_no_rsp", sample(), idle_o, 1'b1);
        #3;
        drive(1, 1, 'h55, 3, 1, 0, 0);
        P_rst_n = 1'b1;
        step();
        drive(0, 0, 0, 0, 1, 0, 0);
        check("rst_first_cmd", sample(),
              '{cmd_ready: 1'b0, selx: 1'b1, enable: 1'b0, write: 1'b1, addr: 'h55,
                wdata: 3, default: '0}, 1'b0);
        step();
        step();
        check("rst_first_rsp", sample(),
              '{cmd_ready: 1'b1, rsp_valid: 1'b1, default: '0}, 1'b0);
        step();

`ifdef APB_MASTER_TIMEOUT_EN
        // P_ready held low: four wait cycles, then abort.
        drive(1, 0, 'h66, 0, 0, 0, 'hAB);
        step();
        drive(0, 0, 0, 0, 0, 0, 'hAB);
        step();
        for (int i = 0; i < int'(TO); i++) begin
            check($sformatf("to_wait%0d", i), sample(),
                  '{selx: 1'b1, enable: 1'b1, addr: 'h66, default: '0}, 1'b0);
            step();
        end
        check("to_abort", sample(),
              '{cmd_ready: 1'b1, rsp_valid: 1'b1, rsp_err: 1'b1, rsp_timeout: 1'b1,
                default: '0}, 1'b0);
        step();
        // P_ready arriving on the last allowed cycle completes normally.
        drive(1, 0, 'h67, 0, 0, 0, 'hCD);
        step();
        drive(0, 0, 0, 0, 0, 0, 'hCD);
        step();
        for (int i = 0; i < int'(TO) - 1; i++) step();
        P_ready = 1'b1;
        check("to_edge_access", sample(),
              '{selx: 1'b1, enable: 1'b1, addr: 'h67, default: '0}, 1'b0);
        step();
        P_ready = 1'b0;
        check("to_edge_rsp", sample(),
              '{cmd_ready: 1'b1, rsp_valid: 1'b1, rsp_rdata: 'hCD, default: '0}, 1'b0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
